neuron_mac: RTL and testbench

//  Output-layer neuron for the MLP datapath. Accepts N_INPUTS (activation, weight) pairs serially.

---
 rtl/mlp_pkg.sv | 19 +
 rtl/q_sat_shift.sv | 40 ++++
 rtl/neuron_mac.sv | 115 +++++++++++
 tb/tb_neuron_mac.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath: Q8.8 format constants and the
// neuron controller state encoding.
package mlp_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/q_sat_shift.sv
// Combinational rescale of a wide accumulator sum to a DATA_W fixed-point
// result: floor shift, saturate to the signed output range, optional ReLU.
module q_sat_shift #(
  parameter int ACC_W     = 40,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter bit RELU      = 1'b1
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic signed [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  always_comb begin
    shifted = sum >>> FRAC_BITS;
    if (shifted > MAX_V) begin
      sat = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      sat = MIN_V[DATA_W-1:0];
    end else begin
      sat = shifted[DATA_W-1:0];
    end
  end

  generate
    if (RELU) begin : g_relu
      assign result = sat[DATA_W-1] ? '0 : sat;
    end else begin : g_linear
      assign result = sat;
    end
  endgenerate

endmodule

// File: rtl/neuron_mac.sv
// Output-layer neuron: serial multiply-accumulate of N_INPUTS pairs, bias add,
// then Q8.8 rescale; result is held with a done level for the softmax stage.
module neuron_mac #(
  parameter int N_INPUTS  = 16,
  parameter int DATA_W    = mlp_pkg::DATA_W,
  parameter int FRAC_BITS = mlp_pkg::FRAC_BITS,
  parameter int ACC_W     = 40,
  parameter bit RELU      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] out
);
  import mlp_pkg::*;

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  state_t                    state_reg, state_next;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic                      done_reg, done_next;
  logic signed [DATA_W-1:0]  out_reg, out_next;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum;
  logic signed [DATA_W-1:0]   sat_result;

  assign prod = in_data * w_data;
  // Bias is aligned to the product scale (2*FRAC_BITS) before the add.
  assign sum  = acc_reg + (ACC_W'(bias) <<< FRAC_BITS);

  q_sat_shift #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .RELU      (RELU)
  ) u_sat (
    .sum    (sum),
    .result (sat_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_next = acc_reg + ACC_W'(prod);
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = FINAL;
          end
        end
      end
      FINAL: begin
        out_next   = sat_result;
        done_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        // Dropping done here gives softmax a fresh rising edge per run.
        if (start) begin
          state_next = ACCUM;
          done_next  = 1'b0;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready = (state_reg == ACCUM);
  assign busy     = (state_reg == ACCUM) || (state_reg == FINAL);
  assign done     = done_reg;
  assign out      = out_reg;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: ReLU and linear instances share stimulus; expected
// results are queued at drive time and popped on each rising edge of done.
module tb_neuron_mac;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data, w_data, bias;
  logic        ready_relu, busy_relu, done_relu;
  logic        ready_lin, busy_lin, done_lin;
  logic [15:0] out_relu, out_lin;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rises  = 0;

  logic [15:0] exp_relu_q[$];
  logic [15:0] exp_lin_q[$];
  string       tag_q[$];

  neuron_mac #(.N_INPUTS(N), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU(1'b1)) u_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .w_data(w_data), .bias(bias),
    .in_ready(ready_relu), .busy(busy_relu), .done(done_relu), .out(out_relu)
  );

  neuron_mac #(.N_INPUTS(N), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU(1'b0)) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .w_data(w_data), .bias(bias),
    .in_ready(ready_lin), .busy(busy_lin), .done(done_lin), .out(out_lin)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input longint acc, input logic [15:0] b, input bit relu);
    longint s, r;
    s = acc + (longint'($signed(b)) * 256);
    r = s >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  // Softmax-side view: sample on negedge, act on each rising edge of done.
  initial begin
    bit    prev;
    string t;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_relu && !prev) begin
        rises++;
        if (exp_relu_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          t = tag_q.pop_front();
          $display("run %s: out_relu=0x%04h out_lin=0x%04h", t, out_relu, out_lin);
          check({t, "_out_relu"}, out_relu, exp_relu_q.pop_front());
          check({t, "_out_lin"}, out_lin, exp_lin_q.pop_front());
          check({t, "_done_lin"}, done_lin, 32'd1);
        end
      end
      prev = done_relu;
    end
  end

  task automatic run_inf(input string tag, input logic [15:0] a0, input logic [15:0] w0,
                         input logic [15:0] b, input bit gaps, input bit rnd);
    longint      acc;
    int          n, t0, last_edge, r0;
    bit          slot, got;
    logic [15:0] a, w;
    acc = 0; n = 0; slot = 1'b1; got = 1'b0; last_edge = 0;
    r0 = rises;
    bias  = b;
    start = 1'b1;
    if (gaps) begin
      in_valid = 1'b1; in_data = 16'h1234; w_data = 16'h4321;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    check({tag, "_done_low"}, done_relu, 32'd0);
    check({tag, "_in_ready"}, ready_relu, 32'd1);
    while (n < N) begin
      a = rnd ? 16'($urandom) : a0;
      w = rnd ? 16'($urandom) : w0;
      if (slot) begin
        in_valid = 1'b1; in_data = a; w_data = w; start = 1'b0;
      end else begin
        in_valid = 1'b0; in_data = 16'hDEAD; w_data = 16'hBEEF; start = 1'b1;
      end
      @(posedge clk);
      if (slot) begin
        acc += longint'($signed(a)) * longint'($signed(w));
        n++;
      end
      #1;
      if (slot) last_edge = cyc;
      if (gaps) slot = !slot;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    exp_relu_q.push_back(model(acc, b, 1'b1));
    exp_lin_q.push_back(model(acc, b, 1'b0));
    tag_q.push_back(tag);
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (done_relu) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      exp_relu_q.delete(); exp_lin_q.delete(); tag_q.delete();
    end else begin
      check({tag, "_latency_last"}, cyc - last_edge, 32'd1);
      if (!gaps) check({tag, "_latency_start"}, cyc - t0, N + 1);
      check({tag, "_busy_done"}, busy_relu, 32'd0);
    end
    #1;
    check({tag, "_one_rise"}, rises - r0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_data = '0; w_data = '0; bias = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {done_relu, done_lin}, 32'd0);
    check("rst_out", {out_relu, out_lin}, 32'd0);
    check("rst_busy", {busy_relu, busy_lin}, 32'd0);
    check("rst_ready", {ready_relu, ready_lin}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_inf("basic",      16'h0100, 16'h0200, 16'h0080, 1'b0, 1'b0);
    run_inf("sat_pos",    16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    run_inf("sat_neg",    16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    run_inf("sign_relu",  16'h0100, 16'hFF00, 16'h0000, 1'b0, 1'b0);
    run_inf("trunc",      16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0);
    run_inf("bias_floor", 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    run_inf("backpress",  16'h0100, 16'h0200, 16'h0080, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_inf($sformatf("rand%0d", i), 16'h0, 16'h0, 16'($urandom), i[0], 1'b1);
    end

    // Reset after two accepted pairs must abandon the run silently.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'h0100; w_data = 16'h0200;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    r0 = rises;
    @(posedge clk);
    #1;
    check("midrst_done", {done_relu, done_lin}, 32'd0);
    check("midrst_out", {out_relu, out_lin}, 32'd0);
    check("midrst_busy", {busy_relu, busy_lin}, 32'd0);
    check("midrst_ready", {ready_relu, ready_lin}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_done", rises - r0, 32'd0);
    check("midrst_idle", {busy_relu, ready_relu}, 32'd0);
    run_inf("after_rst", 16'h0100, 16'h0200, 16'h0080, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_relu_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
